// File: rtl/exec_phase_ir_alu_pkg.sv
// Shared constants for the execution front end:
// opcodes, instruction classes, phase encodings and flag indices.
package exec_phase_ir_alu_pkg;

  localparam int WIDTH = 16;

  localparam logic [1:0] CLS_LD   = 2'b00;
  localparam logic [1:0] CLS_ST   = 2'b01;
  localparam logic [1:0] CLS_BR   = 2'b10;
  localparam logic [1:0] CLS_CALC = 2'b11;

  localparam logic [3:0] IADD  = 4'b0000;
  localparam logic [3:0] ISUB  = 4'b0001;
  localparam logic [3:0] IAND  = 4'b0010;
  localparam logic [3:0] IOR   = 4'b0011;
  localparam logic [3:0] IXOR  = 4'b0100;
  localparam logic [3:0] ICMP  = 4'b0101;
  localparam logic [3:0] IMOV  = 4'b0110;
  localparam logic [3:0] ISLL  = 4'b1000;
  localparam logic [3:0] ISLR  = 4'b1001;
  localparam logic [3:0] ISRL  = 4'b1010;
  localparam logic [3:0] ISRA  = 4'b1011;
  localparam logic [3:0] IIDT  = 4'b1100;
  localparam logic [3:0] IOUT  = 4'b1101;
  localparam logic [3:0] IHALT = 4'b1111;

  localparam logic [4:0] P1 = 5'b00001;
  localparam logic [4:0] P2 = 5'b00010;
  localparam logic [4:0] P3 = 5'b00100;
  localparam logic [4:0] P4 = 5'b01000;
  localparam logic [4:0] P5 = 5'b10000;

  localparam int FLAG_S = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/exec_phase_ir_alu_alu.sv
// Combinational ALU: result, next flags and
// whether this instruction is allowed to write the flags.
module exec_alu_core
  import exec_phase_ir_alu_pkg::*;
(
  input  logic [15:0] ir_i,
  input  logic [15:0] ar_i,
  input  logic [15:0] br_i,
  output logic [15:0] res_o,
  output logic [3:0]  flags_o,
  output logic        flag_we_o
);

  logic [1:0]  cls;
  logic [3:0]  op;
  logic [3:0]  sh;
  logic        nz;
  logic [16:0] sum;
  logic [16:0] dif;
  logic [16:0] sll;
  logic [16:0] srl;
  logic [16:0] sra;
  logic [31:0] rol;
  logic        c;
  logic        v;

  assign cls = ir_i[15:14];
  assign op  = ir_i[7:4];
  assign sh  = br_i[3:0];
  assign nz  = (sh != 4'd0);
  assign sum = {1'b0, ar_i} + {1'b0, br_i};
  assign dif = {1'b0, ar_i} - {1'b0, br_i};
  // Extra bit on the shifted-out side catches the carry
  assign sll = {1'b0, ar_i} << sh;
  assign srl = {ar_i, 1'b0} >> sh;
  assign sra = $signed({ar_i, 1'b0}) >>> sh;
  assign rol = {ar_i, ar_i} << sh;

  always_comb begin
    res_o     = '0;
    c         = 1'b0;
    v         = 1'b0;
    flag_we_o = 1'b0;
    case (cls)
      CLS_CALC: begin
        case (op)
          IADD: begin
            res_o     = sum[15:0];
            c         = sum[16];
            v         = (ar_i[15] == br_i[15]) &&
                        (sum[15] != ar_i[15]);
            flag_we_o = 1'b1;
          end
          ISUB, ICMP: begin
            res_o     = dif[15:0];
            c         = dif[16];
            v         = (ar_i[15] != br_i[15]) &&
                        (dif[15] != ar_i[15]);
            flag_we_o = 1'b1;
          end
          IAND: begin
            res_o     = ar_i & br_i;
            flag_we_o = 1'b1;
          end
          IOR: begin
            res_o     = ar_i | br_i;
            flag_we_o = 1'b1;
          end
          IXOR: begin
            res_o     = ar_i ^ br_i;
            flag_we_o = 1'b1;
          end
          IMOV: begin
            res_o     = br_i;
            flag_we_o = 1'b1;
          end
          ISLL: begin
            res_o     = sll[15:0];
            c         = nz & sll[16];
            flag_we_o = 1'b1;
          end
          ISLR: begin
            res_o     = rol[31:16];
            c         = nz & rol[16];
            flag_we_o = 1'b1;
          end
          ISRL: begin
            res_o     = srl[16:1];
            c         = nz & srl[0];
            flag_we_o = 1'b1;
          end
          ISRA: begin
            res_o     = sra[16:1];
            c         = nz & sra[0];
            flag_we_o = 1'b1;
          end
          IIDT, IOUT: res_o = br_i;
          default:    res_o = '0;
        endcase
      end
      CLS_BR:  res_o = br_i;
      default: res_o = sum[15:0];
    endcase
  end

  always_comb begin
    flags_o         = '0;
    flags_o[FLAG_S] = res_o[15];
    flags_o[FLAG_Z] = (res_o == 16'd0);
    flags_o[FLAG_C] = c;
    flags_o[FLAG_V] = v;
  end

endmodule

// File: rtl/exec_phase_ir_alu.sv
// Execution front end: five-phase sequencer, instruction
// register loaded in P1, and flag register written in P3.
module exec_phase_ir_alu
  import exec_phase_ir_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] mem_data,
  input  logic [WIDTH-1:0] ar,
  input  logic [WIDTH-1:0] br,
  output logic [4:0]       phase,
  output logic [WIDTH-1:0] ir,
  output logic [WIDTH-1:0] alu_out,
  output logic [3:0]       flags
);

  logic [4:0]  phase_q, phase_d;
  logic [15:0] ir_q;
  logic [3:0]  flags_q;
  logic [3:0]  flags_nx;
  logic        flag_we;

  exec_alu_core u_alu (
    .ir_i      (ir_q),
    .ar_i      (ar),
    .br_i      (br),
    .res_o     (alu_out),
    .flags_o   (flags_nx),
    .flag_we_o (flag_we)
  );

  // Any non-one-hot value recovers to P1
  always_comb begin
    case (phase_q)
      P1:      phase_d = P2;
      P2:      phase_d = P3;
      P3:      phase_d = P4;
      P4:      phase_d = P5;
      default: phase_d = P1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= P1;
      ir_q    <= '0;
      flags_q <= '0;
    end else begin
      phase_q <= phase_d;
      if (phase_q == P1)
        ir_q <= mem_data;
      if (phase_q == P3 && flag_we)
        flags_q <= flags_nx;
    end
  end

  assign phase = phase_q;
  assign ir    = ir_q;
  assign flags = flags_q;

endmodule

// File: tb/tb_exec_phase_ir_alu.sv
// Directed bench with a behavioural model of the
// sequencer, IR, ALU and flag register.
module tb_exec_phase_ir_alu;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] mem_data, ar, br;
  logic [4:0]  phase;
  logic [15:0] ir, alu_out;
  logic [3:0]  flags;

  int total = 0;
  int bad   = 0;
  bit started = 0;

  int          m_idx = 0;
  logic [15:0] m_ir  = 0;
  logic [3:0]  m_fl  = 0;

  exec_phase_ir_alu #(.WIDTH(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .mem_data (mem_data),
    .ar       (ar),
    .br       (br),
    .phase    (phase),
    .ir       (ir),
    .alu_out  (alu_out),
    .flags    (flags)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  // Spec-level ALU: integer arithmetic, bit-at-a-time shifts
  task automatic m_alu(input logic [15:0] i, input logic [15:0] a,
                       input logic [15:0] b, output logic [15:0] r,
                       output logic [3:0] f, output bit upd);
    int x, y, s, n, c, vv;
    x = a; y = b; c = 0; vv = 0; upd = 0; s = 0;
    n = y % 16;
    if (i[15:14] == 2'b10) s = y;
    else if (i[15:14] != 2'b11) s = (x + y) % 65536;
    else begin
      upd = 1;
      case (i[7:4])
        0: begin
          s = x + y; c = (s > 65535); s = s % 65536;
          vv = (sgn(x) + sgn(y) > 32767) || (sgn(x) + sgn(y) < -32768);
        end
        1, 5: begin
          c = (x < y); s = (x - y + 65536) % 65536;
          vv = (sgn(x) - sgn(y) > 32767) || (sgn(x) - sgn(y) < -32768);
        end
        2: s = x & y;
        3: s = x | y;
        4: s = x ^ y;
        6: s = y;
        8: begin
          s = x;
          for (int k = 0; k < n; k++) begin
            c = (s >> 15) & 1; s = (s * 2) % 65536;
          end
        end
        9: begin
          s = x;
          for (int k = 0; k < n; k++) begin
            c = (s >> 15) & 1; s = (s * 2) % 65536 + c;
          end
        end
        10: begin
          s = x;
          for (int k = 0; k < n; k++) begin
            c = s & 1; s = s / 2;
          end
        end
        11: begin
          s = x;
          for (int k = 0; k < n; k++) begin
            c = s & 1; s = s / 2 + (s & 32768);
          end
        end
        12, 13: begin s = y; upd = 0; end
        default: begin s = 0; upd = 0; end
      endcase
    end
    r = s[15:0];
    f = {vv[0], c[0], (s == 0), r[15]};
  endtask

  always @(posedge clock) begin
    logic [15:0] r;
    logic [3:0]  f;
    bit          u;
    if (reset) begin
      m_idx = 0; m_ir = 0; m_fl = 0;
    end else begin
      m_alu(m_ir, ar, br, r, f, u);
      if (m_idx == 2 && u) m_fl = f;
      if (m_idx == 0) m_ir = mem_data;
      m_idx = (m_idx + 1) % 5;
    end
  end

  always @(negedge clock) begin
    logic [15:0] r;
    logic [3:0]  f;
    bit          u;
    if (started) begin
      m_alu(m_ir, ar, br, r, f, u);
      chk("m_phase", {11'd0, phase}, 16'(1 << m_idx));
      chk("m_ir", ir, m_ir);
      chk("m_alu", alu_out, r);
      chk("m_flags", {12'd0, flags}, {12'd0, m_fl});
    end
  end

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic load(input logic [15:0] instr);
    for (int k = 0; k < 5 && m_idx != 0; k++) tick();
    total++;
    if (m_idx != 0) begin
      bad++;
      $display("FAIL load_sync: got idx %0d want 0", m_idx);
    end
    mem_data = instr;
    tick();
  endtask

  task automatic run_calc(input string nm, input logic [15:0] instr,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] ex, input logic [3:0] exf);
    load(instr);
    ar = a; br = b;
    tick();
    chk({nm, "_alu"}, alu_out, ex);
    tick();
    chk({nm, "_flags"}, {12'd0, flags}, {12'd0, exf});
  endtask

  logic [15:0] sh_ir [4] = '{16'hC0B0, 16'hC0A0, 16'hC080, 16'hC090};
  logic [15:0] sh_ex [4] = '{16'hC000, 16'h4000, 16'h0002, 16'h0003};
  logic [3:0]  sh_fl [4] = '{4'b0101, 4'b0100, 4'b0100, 4'b0100};
  logic [4:0]  walk  [6] = '{5'h02, 5'h04, 5'h08, 5'h10, 5'h01, 5'h02};

  initial begin
    reset = 1; mem_data = 0; ar = 0; br = 0;
    tick();
    started = 1;
    tick();
    reset = 0;
    chk("rst_phase", {11'd0, phase}, 16'h0001);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_flags", {12'd0, flags}, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("walk", {11'd0, phase}, {11'd0, walk[i]});
    end
    mem_data = 16'hC800;
    tick();
    chk("ir_noload_p3", ir, 16'h0000);
    repeat (3) tick();
    chk("ir_noload_p1", ir, 16'h0000);
    tick();
    chk("ir_load", ir, 16'hC800);
    mem_data = 16'h1234;
    repeat (4) tick();
    chk("ir_hold", ir, 16'hC800);

    run_calc("add_ovf", 16'hC000, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001);
    run_calc("cmp_eq", 16'hC050, 16'h0005, 16'h0005, 16'h0000, 4'b0010);
    load(16'hB80A);
    br = 16'h000A;
    tick();
    chk("br_alu", alu_out, 16'h000A);
    repeat (2) tick();
    chk("br_flags_p5", {12'd0, flags}, 16'h0002);
    tick();
    chk("br_flags_p1", {12'd0, flags}, 16'h0002);

    for (int i = 0; i < 4; i++)
      run_calc("shift", sh_ir[i], 16'h8001, 16'h0001, sh_ex[i], sh_fl[i]);
    run_calc("ld_addr", 16'h0105, 16'hFFFE, 16'h0005, 16'h0003, 4'b0100);
    run_calc("sub_brw", 16'hC010, 16'h0000, 16'h0001, 16'hFFFF, 4'b0101);
    run_calc("halt", 16'hC0F0, 16'h0001, 16'h0001, 16'h0000, 4'b0101);
    run_calc("sll0", 16'hC080, 16'h8001, 16'h0000, 16'h8001, 4'b0001);

    load(16'hC000);
    ar = 16'h7FFF; br = 16'h0001;
    tick();
    reset = 1;
    tick();
    reset = 0;
    chk("mid_rst_phase", {11'd0, phase}, 16'h0001);
    chk("mid_rst_ir", ir, 16'h0000);
    chk("mid_rst_flags", {12'd0, flags}, 16'h0000);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
